prio_event_encoder: RTL
=======================

PRIO_EVENT_ENCODER -- requirements
Module: prio_event_encoder

Interface
REQ-001 Parameter N, default 8, number of request inputs; SHALL be legal for any N >= 2.
REQ-002 Parameter W, default $clog2(N) (3 for N=8), index width; SHALL be derived from N and never overridden independently.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  N  event pulses; a bit high for one cycle is one event.
REQ-006 mode  input  1  selection mode: 0 = fixed priority, highest index wins; 1 = round-robin.
REQ-007 out_ready  input  1  consumer accepts the offered index when high together with out_valid.
REQ-008 out_valid  output  1  out_idx holds a pending event index.
REQ-009 out_idx  output  W  encoded index of the offered event.
REQ-010 pending  output  N  latched, not-yet-accepted events.
REQ-011 drop_cnt  output  8  saturating count of cycles in which an event was coalesced.

Function
REQ-012 Handshake: acceptance (hs) SHALL occur on any rising edge with out_valid=1 and out_ready=1.
REQ-013 Pending update: pending <= (pending & ~clr) | req, where clr = onehot(out_idx) on hs and 0 otherwise.
REQ-014 Same-cycle req and clr on one bit: the bit SHALL remain set (new event re-pends, not lost).
REQ-015 Coalescing: a req bit arriving while its pending bit is set and not cleared that cycle SHALL be merged into the existing event.
REQ-016 drop_cnt SHALL increment by 1 per cycle with at least one coalesced bit, saturating at 255; only rst clears it.
REQ-017 Output register loads when out_valid=0 or hs; otherwise out_valid and out_idx SHALL hold stable (no change under backpressure).
REQ-018 On load, selection SHALL use sel = pending & ~clr (registered pending only, not this cycle's req).
REQ-019 Load result: out_valid <= |sel; out_idx <= chosen index, or 0 when sel is 0.
REQ-020 Latency: req on edge k -> pending visible after k -> out_valid after edge k+1 (2 cycles, idle output).
REQ-021 Back-to-back throughput: with out_ready held high and events pending, one index SHALL be accepted every cycle.
REQ-022 Fixed mode: chosen index SHALL be the highest set bit of sel.
REQ-023 Pointer ptr (W bits) SHALL take the accepted out_idx on every hs, in both modes.
REQ-024 Round-robin search order: ptr-1, ptr-2, ... downward with wrap from 0 to N-1, ending at ptr; the first set bit of sel wins.
REQ-025 Round-robin arithmetic SHALL be modulo N, including N not a power of 2.
REQ-026 A mode change SHALL affect only the next load and SHALL NOT disturb a held offer.
REQ-027 No event is dropped except by coalescing; every set pending bit SHALL eventually be offered while out_ready toggles high.

Reset
REQ-028 rst=1 at an edge: pending=0, out_valid=0, out_idx=0, ptr=0, drop_cnt=0.
REQ-029 rst SHALL dominate req and hs in the same cycle; neither is recorded.
REQ-030 Reset mid-offer SHALL discard the offer and all pending events with no partial state.
REQ-031 After reset with ptr=0, round-robin order starts at N-1, identical to fixed mode.

Verification
REQ-032 N=8, mode=0, out_ready=1, req=0x24 for 1 cycle at edge k -> out_idx=5 valid after k+1, out_idx=2 after k+2, out_valid=0 after k+3.
REQ-033 Backpressure: out_ready=0, req=0x80 then 0x01 -> out_idx=7 held stable, pending=0x81; out_ready=1 -> 7 accepted, then 0, then idle.
REQ-034 Round-robin, mode=1, last accepted 7, req=0x81 -> order 0 then 7; same stimulus in mode=0 -> order 7 then 0.
REQ-035 Coalesce: bit 3 offered with out_ready=0, req bit 3 pulsed twice -> drop_cnt=2; hs with req bit 3 in the same cycle -> idx 3 offered again, drop_cnt stays 2.
REQ-036 rst during out_valid=1, pending=0x0F, req=0x10 -> next cycle all outputs 0 and 0x10 is not recorded.
REQ-037 N=5, mode=1, req=0x1F single pulse -> acceptance order 4,3,2,1,0; pulse req=0x11 after that -> 4 then 0 (wrap).

Source files
------------

// File: rtl/prio_event_encoder.sv
// prio_event_encoder
//
// Latches single-cycle event pulses into a pending vector and offers one
// pending event index at a time through a valid/ready output register.
// Selection is either fixed priority (highest index wins) or round-robin
// (search downward from the last accepted index, wrapping modulo N).
// Events that arrive on an already-pending, not-yet-cleared bit are merged
// into the existing event, and each cycle with such a merge is counted.
//
// Parameters
//   N          number of request inputs (N >= 2)
//   W          index width, always $clog2(N)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   req        [N-1:0] event pulses, one cycle high = one event
//   mode       0 = fixed priority, 1 = round-robin
//   out_ready  consumer accepts out_idx when high with out_valid
//   out_valid  out_idx holds a pending event index
//   out_idx    [W-1:0] encoded index of the offered event
//   pending    [N-1:0] latched, not-yet-accepted events
//   drop_cnt   [7:0] saturating count of cycles with a merged event
module prio_event_encoder #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic [7:0]   drop_cnt
);

  localparam int unsigned NU = N;

  logic         hs;
  logic [N-1:0] clr;
  logic [N-1:0] sel;
  logic [N-1:0] coalesce;
  logic [W-1:0] ptr;
  logic [W-1:0] ptr_eff;
  logic [W-1:0] fix_idx;
  logic [W-1:0] rr_idx;
  logic         rr_found;
  logic         load;
  int unsigned  base;
  int unsigned  cand;

  // Handshake, clear mask and the selection set for this cycle.
  always_comb begin
    hs       = out_valid & out_ready;
    clr      = '0;
    if (hs) begin
      clr[out_idx] = 1'b1;
    end
    sel      = pending & ~clr;
    coalesce = req & sel;
    load     = ~out_valid | hs;
    // The pointer is updated to the accepted index on this same edge, so
    // a reload during a handshake searches from that index already.
    ptr_eff  = hs ? out_idx : ptr;
  end

  // Fixed priority: the highest set bit of sel wins.
  always_comb begin
    fix_idx = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (sel[i]) begin
        fix_idx = W'(i);
      end
    end
  end

  // Round-robin: visit ptr-1, ptr-2, ... wrapping from 0 to N-1, ending at
  // ptr itself; the first set bit of sel wins. The wrap is done with a
  // conditional subtract so non-power-of-two N stays modulo N.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    base     = 32'(ptr_eff);
    cand     = 0;
    for (int unsigned k = 1; k <= NU; k++) begin
      cand = base + NU - k;
      if (cand >= NU) begin
        cand = cand - NU;
      end
      if (!rr_found && sel[cand]) begin
        rr_found = 1'b1;
        rr_idx   = W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      ptr       <= '0;
      drop_cnt  <= '0;
    end else begin
      // A req on a bit cleared this cycle re-pends it as a fresh event.
      pending <= sel | req;

      if ((|coalesce) && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end

      if (hs) begin
        ptr <= out_idx;
      end

      // Offer register only reloads when empty or being accepted, so a
      // held offer is immune to mode changes and new requests.
      if (load) begin
        out_valid <= |sel;
        out_idx   <= mode ? rr_idx : fix_idx;
      end
    end
  end

endmodule
